// File: rtl/lmac_stat_reg_rd_resp.sv
// Register read responder for the LMAC statistics block: saturating event counters,
// a VERSION word, and a fixed-latency one-hot read handshake FSM.
module lmac_stat_reg_rd_resp #(
  parameter logic [15:0] ADDR_BASE   = 16'h0100,
  parameter int          NUM_CNT     = 8,
  parameter int          RD_LATENCY  = 2,
  parameter bit          CLR_ON_READ = 1'b1,
  parameter logic [31:0] VERSION     = 32'h0003_0001
) (
  input  logic               reg_clk,
  input  logic               reset,
  input  logic [15:0]        host_addr,
  input  logic               reg_rd_start,
  output logic [31:0]        mac_regdout,
  output logic               reg_rd_done_out,
  input  logic [NUM_CNT-1:0] stat_evt,
  input  logic               stat_clr,
  output logic               rd_busy
);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    LATCH = 4'b0010,
    WAIT  = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  localparam logic [15:0] VER_OFF   = 16'(4 * NUM_CNT);
  localparam logic [2:0]  WAIT_LAST = 3'(RD_LATENCY - 1);
  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

  state_t                    state_q, state_d;
  logic [15:0]               addr_q, addr_d;
  logic [31:0]               data_q, data_d;
  logic [2:0]                wait_cnt_q, wait_cnt_d;
  logic [NUM_CNT-1:0][31:0]  cnt_q, cnt_d;

  logic [15:0] offset_s;
  logic        in_range_s;
  logic        hit_cnt_s;
  logic        hit_ver_s;
  logic [3:0]  cnt_idx_s;
  logic [31:0] rd_word_s;
  logic        clr_rd_s;

  // Decode the latched address into a counter index or the VERSION word.
  always_comb begin
    offset_s   = addr_q - ADDR_BASE;
    in_range_s = (addr_q >= ADDR_BASE) && (offset_s[1:0] == 2'b00);
    hit_cnt_s  = in_range_s && (offset_s < VER_OFF);
    hit_ver_s  = in_range_s && (offset_s == VER_OFF);
    cnt_idx_s  = offset_s[5:2];
    rd_word_s  = 32'h0;
    if (hit_ver_s) begin
      rd_word_s = VERSION;
    end else if (hit_cnt_s) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (cnt_idx_s == i[3:0]) begin
          rd_word_s = cnt_q[i];
        end else begin
          rd_word_s = rd_word_s;
        end
      end
    end else begin
      rd_word_s = 32'h0;
    end
  end

  // Read handshake FSM: next state, address latch, snapshot and wait counter.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (reg_rd_start) begin
          addr_d  = host_addr;
          state_d = LATCH;
        end else begin
          state_d = IDLE;
        end
      end
      LATCH: begin
        data_d     = rd_word_s;
        wait_cnt_d = 3'd0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counter update: global clear beats clear-on-read beats increment; an event
  // landing on the clear-on-read cycle restarts the counter at 1.
  always_comb begin
    cnt_d    = cnt_q;
    clr_rd_s = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) begin
      clr_rd_s = CLR_ON_READ && (state_q == LATCH) && hit_cnt_s && (cnt_idx_s == i[3:0]);
      if (stat_clr) begin
        cnt_d[i] = 32'h0;
      end else if (clr_rd_s) begin
        cnt_d[i] = stat_evt[i] ? 32'h1 : 32'h0;
      end else if (stat_evt[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + 32'h1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // State, data and counter registers.
  always_ff @(posedge reg_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= 16'h0;
      data_q     <= 32'h0;
      wait_cnt_q <= 3'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wait_cnt_q <= wait_cnt_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mac_regdout     = data_q;
  assign reg_rd_done_out = state_q[3];
  assign rd_busy         = ~state_q[0];

endmodule

// File: tb/tb_lmac_stat_reg_rd_resp.sv
// Directed bench for lmac_stat_reg_rd_resp: table of event/read vectors plus
// hand-written sequences for saturation, LATCH-cycle events/clears, ignored starts and abort.
module tb_lmac_stat_reg_rd_resp;

  localparam int NUM_CNT    = 8;
  localparam int RD_LATENCY = 2;
  localparam int WIN        = 12;

  logic               clk;
  logic               reset;
  logic [15:0]        host_addr;
  logic               reg_rd_start;
  logic [31:0]        mac_regdout;
  logic               reg_rd_done_out;
  logic [NUM_CNT-1:0] stat_evt;
  logic               stat_clr;
  logic               rd_busy;

  int checks;
  int failures;

  lmac_stat_reg_rd_resp dut (
    .reg_clk        (clk),
    .reset          (reset),
    .host_addr      (host_addr),
    .reg_rd_start   (reg_rd_start),
    .mac_regdout    (mac_regdout),
    .reg_rd_done_out(reg_rd_done_out),
    .stat_evt       (stat_evt),
    .stat_clr       (stat_clr),
    .rd_busy        (rd_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  evt_mask;
    int          evt_cycles;
    logic [15:0] addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic pulse_evt(input logic [7:0] mask, input int n);
    for (int c = 0; c < n; c++) begin
      stat_evt = mask;
      @(negedge clk);
    end
    stat_evt = '0;
  endtask

  // One read driven from a negedge; observes a fixed window of negedges.
  task automatic do_read(input string nm, input logic [15:0] a, input logic [31:0] exp,
                         input logic [7:0] latch_evt, input logic latch_clr,
                         input logic extra_start, input logic abort);
    int first_k;
    int pulses;
    logic [31:0] data_at_done;
    first_k      = 0;
    pulses       = 0;
    data_at_done = 32'h0;
    host_addr    = a;
    reg_rd_start = 1'b1;
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk);
      if (k == 1) begin
        reg_rd_start = 1'b0;
        check({nm, " busy_after_start"}, {31'h0, rd_busy}, 32'h1);
        stat_evt = latch_evt;
        stat_clr = latch_clr;
      end else if (k == 2) begin
        stat_evt = '0;
        stat_clr = 1'b0;
        if (extra_start) begin
          host_addr    = 16'h0120;
          reg_rd_start = 1'b1;
        end
        if (abort) reset = 1'b1;
      end else if (k == 3) begin
        reg_rd_start = 1'b0;
        reset        = 1'b0;
      end
      if (reg_rd_done_out) begin
        pulses++;
        if (first_k == 0) begin
          first_k      = k;
          data_at_done = mac_regdout;
        end
      end
    end
    if (abort) begin
      check({nm, " abort_pulses"}, 32'(pulses), 32'd0);
      check({nm, " abort_data"}, mac_regdout, 32'h0);
      check({nm, " abort_busy"}, {31'h0, rd_busy}, 32'h0);
    end else begin
      check({nm, " done_cycle"}, 32'(first_k), 32'(2 + RD_LATENCY));
      check({nm, " done_pulses"}, 32'(pulses), 32'd1);
      check({nm, " data"}, data_at_done, exp);
      check({nm, " data_held"}, mac_regdout, exp);
      check({nm, " idle_busy"}, {31'h0, rd_busy}, 32'h0);
    end
  endtask

  initial begin
    logic [NUM_CNT*32-1:0] force_val;
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    host_addr    = 16'h0;
    reg_rd_start = 1'b0;
    stat_evt     = '0;
    stat_clr     = 1'b0;

    vecs[0] = '{"rd_cnt0_zero",   8'h00, 0, 16'h0100, 32'h0};
    vecs[1] = '{"rd_cnt2_five",   8'h04, 5, 16'h0108, 32'd5};
    vecs[2] = '{"rd_cnt2_clred",  8'h00, 0, 16'h0108, 32'h0};
    vecs[3] = '{"rd_version",     8'h00, 0, 16'h0120, 32'h0003_0001};
    vecs[4] = '{"rd_misaligned",  8'h00, 0, 16'h0102, 32'h0};
    vecs[5] = '{"rd_unmapped",    8'h00, 0, 16'h0200, 32'h0};
    vecs[6] = '{"rd_cnt7_three",  8'h81, 3, 16'h011C, 32'd3};
    vecs[7] = '{"rd_cnt0_three",  8'h00, 0, 16'h0100, 32'd3};
    vecs[8] = '{"rd_below_base",  8'h00, 0, 16'h00FC, 32'h0};
    vecs[9] = '{"rd_past_ver",    8'h00, 0, 16'h0124, 32'h0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_data", mac_regdout, 32'h0);
    check("reset_done", {31'h0, reg_rd_done_out}, 32'h0);
    check("reset_busy", {31'h0, rd_busy}, 32'h0);

    for (int v = 0; v < 10; v++) begin
      pulse_evt(vecs[v].evt_mask, vecs[v].evt_cycles);
      do_read(vecs[v].name, vecs[v].addr, vecs[v].exp, 8'h00, 1'b0, 1'b0, 1'b0);
    end

    // Saturation: deposit 0xFFFF_FFFE into counter 0, then three events.
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr  = 1'b0;
    force_val = '0;
    force_val[31:0] = 32'hFFFF_FFFE;
    force dut.cnt_q = force_val;
    @(negedge clk);
    release dut.cnt_q;
    pulse_evt(8'h01, 3);
    do_read("sat_cnt0", 16'h0100, 32'hFFFF_FFFF, 8'h00, 1'b0, 1'b0, 1'b0);

    // Event on counter 1 during its clear-on-read LATCH cycle.
    pulse_evt(8'h02, 7);
    do_read("latch_evt_cnt1", 16'h0104, 32'd7, 8'h02, 1'b0, 1'b0, 1'b0);
    do_read("latch_evt_cnt1_after", 16'h0104, 32'd1, 8'h00, 1'b0, 1'b0, 1'b0);

    // Global clear in the LATCH cycle: snapshot is pre-clear, all counters end at 0.
    pulse_evt(8'h0C, 4);
    do_read("clr_in_latch_cnt2", 16'h0108, 32'd4, 8'h00, 1'b1, 1'b0, 1'b0);
    do_read("clr_in_latch_cnt3", 16'h010C, 32'd0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Second start while in WAIT is ignored.
    pulse_evt(8'h20, 2);
    do_read("ignored_start", 16'h0114, 32'd2, 8'h00, 1'b0, 1'b1, 1'b0);

    // Reset during WAIT aborts the read; a prior nonzero snapshot is cleared.
    do_read("pre_abort_ver", 16'h0120, 32'h0003_0001, 8'h00, 1'b0, 1'b0, 1'b0);
    pulse_evt(8'h10, 2);
    do_read("abort", 16'h0110, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    do_read("post_abort_cnt4", 16'h0110, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
